// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the buffered UART bridge.
package uart_fifo_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GUARD = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  // Occupancy counters need one bit beyond the address so that "full" is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with pointer-difference occupancy.
// A push to a full FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [count_width(DEPTH)-1:0] count_o,
  output logic                          drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  pop_ok;
  logic                  push_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign count_o = count;
  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  // Head is presented directly; zero while empty so the output is defined after reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered UART port: RX/TX FIFOs, transmit sequencer for the start/busy handshake,
// and sticky overflow flags.
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int BUSY_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rxReady,
  input  logic [DATA_WIDTH-1:0]            rxData,
  output logic                             rxValid,
  output logic [DATA_WIDTH-1:0]            rxOutData,
  input  logic                             rxPop,
  input  logic                             txPush,
  input  logic [DATA_WIDTH-1:0]            txInData,
  output logic                             txFull,
  input  logic                             txBusy,
  output logic                             txStart,
  output logic [DATA_WIDTH-1:0]            txData,
  output logic [count_width(RX_DEPTH)-1:0] rxCount,
  output logic [count_width(TX_DEPTH)-1:0] txCount,
  output logic                             rxOverflow,
  output logic                             txOverflow,
  input  logic                             clearFlags
);

  localparam int GW = $clog2(BUSY_LATENCY + 1);

  logic                  rx_empty, rx_drop;
  logic                  tx_empty, tx_drop, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  seq_state_e            state_q, state_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic                  tx_ovf_q, tx_ovf_d;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rxReady),
    .data_i  (rxData),
    .pop_i   (rxPop),
    .data_o  (rxOutData),
    .full_o  (),
    .empty_o (rx_empty),
    .count_o (rxCount),
    .drop_o  (rx_drop)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (txPush),
    .data_i  (txInData),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (txFull),
    .empty_o (tx_empty),
    .count_o (txCount),
    .drop_o  (tx_drop)
  );

  assign rxValid    = ~rx_empty;
  assign txData     = tx_data_q;
  assign rxOverflow = rx_ovf_q;
  assign txOverflow = tx_ovf_q;

  // Sticky flags: a new drop wins over a simultaneous clear.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (clearFlags) begin
      rx_ovf_d = 1'b0;
      tx_ovf_d = 1'b0;
    end
    if (rx_drop) rx_ovf_d = 1'b1;
    if (tx_drop) tx_ovf_d = 1'b1;
  end

  // Sequencer next state: dequeue, pulse start, blind window for txBusy, then wait idle.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    txStart   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_head;
          state_d   = START;
        end
      end
      START: begin
        txStart = 1'b1;
        guard_d = GW'(BUSY_LATENCY);
        state_d = GUARD;
      end
      GUARD: begin
        guard_d = guard_q - 1'b1;
        if (guard_q == GW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      tx_data_q <= '0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

endmodule
